result_packetizer: RTL and testbench

RESULT_PACKETIZER -- requirements
Module: result_packetizer

---
 rtl/result_packetizer_pkg.sv | 26 ++
 rtl/result_packetizer.sv | 152 +++++++++++++++
 tb/tb_result_packetizer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/result_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// result_packetizer_pkg
// Shared definitions for the result packetizer and anything that decodes its
// frames: the frame sync byte, the status codes and the FSM state encoding.
// -----------------------------------------------------------------------------
package result_packetizer_pkg;

    // First byte of every frame, lets the host resynchronise on a byte stream
    localparam logic [7:0] SYNC_BYTE        = 8'hA5;

    // Status byte values
    localparam logic [7:0] STATUS_FOUND     = 8'h01;
    localparam logic [7:0] STATUS_NOT_FOUND = 8'h00;

    // IDLE    : waiting for start
    // ISSUE   : current byte on uart_data, waiting for the transmitter to be idle
    // WAIT_LO : send strobe given, waiting for the transmitter to take it
    // WAIT_HI : character in flight, waiting for the transmitter to finish
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_e;

endpackage

// File: rtl/result_packetizer.sv
// -----------------------------------------------------------------------------
// result_packetizer
// Turns one search result into a byte frame for a UART transmitter:
//   SYNC_BYTE, STATUS, PAYLOAD_BYTES payload bytes (MSB first), CHECKSUM
// where CHECKSUM is the XOR of STATUS and every payload byte.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle frame request, honoured only when idle
//   found      : result status, latched with start
//   payload    : result data, latched with start, byte 0 in the top 8 bits
//   busy       : high while a frame is being sent
//   done       : one-cycle pulse once the last byte has been sent
//   uart_data  : byte presented to the transmitter
//   uart_send  : one-cycle send strobe to the transmitter
//   uart_ready : transmitter idle flag
// -----------------------------------------------------------------------------
module result_packetizer #(
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter logic [7:0]  SYNC_BYTE     = result_packetizer_pkg::SYNC_BYTE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         found,
    input  logic [8*PAYLOAD_BYTES-1:0]   payload,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   uart_data,
    output logic                         uart_send,
    input  logic                         uart_ready
);

    import result_packetizer_pkg::*;

    localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 3;
    localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);

    localparam logic [IDX_W-1:0] SYNC_IDX   = '0;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BYTES - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [7:0]                   csum_q, csum_d;
    logic [7:0]                   status_q, status_d;
    logic [8*PAYLOAD_BYTES-1:0]   payload_q, payload_d;
    logic                         done_q, done_d;
    logic [7:0]                   cur_byte;
    logic                         accept;

    // A start that lands on the done cycle is dropped: the frame has only
    // just finished and the block is not yet considered idle.
    assign accept = (state_q == IDLE) && start && !done_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = ISSUE;
            ISSUE:   if (uart_ready)  state_d = WAIT_LO;
            WAIT_LO: if (!uart_ready) state_d = WAIT_HI;
            WAIT_HI: if (uart_ready)  state_d = (idx_q == LAST_IDX) ? IDLE : ISSUE;
            default:                  state_d = IDLE;
        endcase
    end

    // Outputs; uart_send only ever comes from ISSUE with the transmitter idle,
    // and ISSUE always leaves on that cycle, so strobes cannot run together.
    always_comb begin
        busy      = (state_q != IDLE);
        uart_send = (state_q == ISSUE) && uart_ready;
        uart_data = (state_q == IDLE) ? 8'h00 : cur_byte;
        done      = done_q;
    end

    // Frame byte selected by the index; the last slot is the running checksum,
    // which is complete by the time the index reaches it.
    always_comb begin
        cur_byte = csum_q;
        if (idx_q == SYNC_IDX) begin
            cur_byte = SYNC_BYTE;
        end else if (idx_q == STATUS_IDX) begin
            cur_byte = status_q;
        end else begin
            for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
                if (idx_q == IDX_W'(k + 2)) begin
                    cur_byte = payload_q[8*(int'(PAYLOAD_BYTES)-1-k) +: 8];
                end
            end
        end
    end

    // Datapath next-state: latch inputs on accept, fold each status/payload
    // byte into the checksum as it is sent, step the index once the
    // transmitter has finished the character.
    always_comb begin
        idx_d     = idx_q;
        csum_d    = csum_q;
        status_d  = status_q;
        payload_d = payload_q;
        done_d    = 1'b0;

        if (accept) begin
            payload_d = payload;
            status_d  = found ? STATUS_FOUND : STATUS_NOT_FOUND;
            idx_d     = '0;
            csum_d    = 8'h00;
        end

        if (uart_send && (idx_q != SYNC_IDX) && (idx_q != LAST_IDX)) begin
            csum_d = csum_q ^ cur_byte;
        end

        if ((state_q == WAIT_HI) && uart_ready) begin
            if (idx_q == LAST_IDX) begin
                done_d = 1'b1;
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            csum_q    <= 8'h00;
            status_q  <= 8'h00;
            payload_q <= '0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            status_q  <= status_d;
            payload_q <= payload_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_result_packetizer.sv
// -----------------------------------------------------------------------------
// tb_result_packetizer
// Two packetizers (8-byte and 1-byte payload), each driving a transmitter
// ready model that goes busy for 40 cycles after every sampled send. Sent
// bytes are collected and compared with hand-computed frames.
// -----------------------------------------------------------------------------
module tb_result_packetizer;

    localparam int BUSY_CYCLES = 40;
    localparam int TIMEOUT     = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        startA = 1'b0;
    logic        foundA = 1'b0;
    logic [63:0] payloadA = '0;
    logic        busyA, doneA, sendA;
    logic [7:0]  dataA;
    logic        readyA = 1'b1;

    logic        startB = 1'b0;
    logic        foundB = 1'b0;
    logic [7:0]  payloadB = '0;
    logic        busyB, doneB, sendB;
    logic [7:0]  dataB;
    logic        readyB = 1'b1;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] capA[$];
    logic [7:0] capB[$];
    int cntA = 0, cntB = 0;
    int doneCntA = 0, doneCntB = 0;
    logic       prevSendA = 1'b0, prevSendB = 1'b0;
    logic [7:0] prevDataA = 8'h00, prevDataB = 8'h00;

    logic [7:0] frame1Exp [11] = '{8'hA5, 8'h01, 8'h68, 8'h75, 8'h6E, 8'h74,
                                   8'h65, 8'h72, 8'h32, 8'h00, 8'h23};
    logic [7:0] frame0Exp [11] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] frameBExp [4]  = '{8'hA5, 8'h01, 8'h5A, 8'h5B};

    localparam logic [63:0] PAYLOAD1 = 64'h68756E7465723200;

    result_packetizer #(.PAYLOAD_BYTES(8)) dutA (
        .clk(clk), .rst(rst), .start(startA), .found(foundA), .payload(payloadA),
        .busy(busyA), .done(doneA), .uart_data(dataA), .uart_send(sendA),
        .uart_ready(readyA)
    );

    result_packetizer #(.PAYLOAD_BYTES(1)) dutB (
        .clk(clk), .rst(rst), .start(startB), .found(foundB), .payload(payloadB),
        .busy(busyB), .done(doneB), .uart_data(dataB), .uart_send(sendB),
        .uart_ready(readyB)
    );

    always #5 clk = ~clk;

    // Counts a comparison and reports it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Transmitter model A: captures the byte and goes busy; not reset by rst,
    // as a real transmitter keeps shifting out its character.
    always @(posedge clk) begin
        if (sendA && readyA) begin
            capA.push_back(dataA);
            readyA <= 1'b0;
            cntA   <= BUSY_CYCLES;
        end else if (cntA > 0) begin
            cntA <= cntA - 1;
            if (cntA == 1) readyA <= 1'b1;
        end
        if (doneA) doneCntA <= doneCntA + 1;
    end

    // Transmitter model B
    always @(posedge clk) begin
        if (sendB && readyB) begin
            capB.push_back(dataB);
            readyB <= 1'b0;
            cntB   <= BUSY_CYCLES;
        end else if (cntB > 0) begin
            cntB <= cntB - 1;
            if (cntB == 1) readyB <= 1'b1;
        end
        if (doneB) doneCntB <= doneCntB + 1;
    end

    // Protocol monitor: send only when ready, never back-to-back, data held
    // after the send, busy low while done pulses.
    always @(negedge clk) begin
        if (sendA) begin
            checkOutput("sendWhileReadyA", 32'(readyA), 32'd1);
            checkOutput("backToBackSendA", 32'(prevSendA), 32'd0);
        end
        if (prevSendA) checkOutput("dataStableA", 32'(dataA), 32'(prevDataA));
        if (doneA) checkOutput("busyWithDoneA", 32'(busyA), 32'd0);
        if (sendB) begin
            checkOutput("sendWhileReadyB", 32'(readyB), 32'd1);
            checkOutput("backToBackSendB", 32'(prevSendB), 32'd0);
        end
        if (prevSendB) checkOutput("dataStableB", 32'(dataB), 32'(prevDataB));
        if (doneB) checkOutput("busyWithDoneB", 32'(busyB), 32'd0);
        prevSendA = sendA;
        prevDataA = dataA;
        prevSendB = sendB;
        prevDataB = dataB;
    end

    // One-cycle start pulse on DUT A
    task automatic applyStimulus(input logic f, input logic [63:0] p);
        @(negedge clk);
        foundA   = f;
        payloadA = p;
        startA   = 1'b1;
        @(negedge clk);
        startA   = 1'b0;
    endtask

    // Waits for done on DUT A with a cycle budget
    task automatic waitDoneA(input string tag);
        int cyc = 0;
        while (!doneA && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (!doneA) checkOutput(tag, 32'(doneA), 32'd1);
    endtask

    // Compares the bytes captured since base against an expected frame
    task automatic checkFrameA(input int base, input logic [7:0] exp [11], input string name);
        checkOutput({name, "_byteCount"}, 32'(capA.size() - base), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (base + i < capA.size())
                checkOutput($sformatf("%s_byte%0d", name, i), 32'(capA[base+i]), 32'(exp[i]));
        end
    endtask

    // Full frame on DUT A, optionally disturbing the inputs mid-frame or
    // requesting again on the done cycle
    task automatic runFrameA(input logic f, input logic [63:0] p, input bit disturb,
                             input bit startOnDone, input logic [7:0] exp [11],
                             input string name);
        int base = capA.size();
        int d0   = doneCntA;
        applyStimulus(f, p);
        checkOutput({name, "_busy"}, 32'(busyA), 32'd1);
        if (disturb) begin
            repeat (4) @(negedge clk);
            startA   = 1'b1;
            foundA   = ~f;
            payloadA = ~p;
            @(negedge clk);
            startA   = 1'b0;
        end
        waitDoneA({name, "_doneTimeout"});
        if (doneA && startOnDone) begin
            startA = 1'b1;
            @(negedge clk);
            startA = 1'b0;
            checkOutput({name, "_startOnDone"}, 32'(busyA), 32'd0);
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_doneCount"}, 32'(doneCntA - d0), 32'd1);
        checkOutput({name, "_busyAfter"}, 32'(busyA), 32'd0);
        checkFrameA(base, exp, name);
    endtask

    initial begin
        int base, base2, d0, cyc;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        checkOutput("rst_done", 32'(doneA), 32'd0);
        checkOutput("rst_send", 32'(sendA), 32'd0);
        checkOutput("rst_data", 32'(dataA), 32'h00);
        checkOutput("rst_busyB", 32'(busyB), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        runFrameA(1'b1, PAYLOAD1, 1'b0, 1'b0, frame1Exp, "found");
        runFrameA(1'b0, 64'h0, 1'b0, 1'b1, frame0Exp, "notFound");
        runFrameA(1'b1, PAYLOAD1, 1'b1, 1'b0, frame1Exp, "disturbed");

        // Reset while the fourth byte is in flight
        base = capA.size();
        applyStimulus(1'b1, PAYLOAD1);
        cyc = 0;
        while (capA.size() - base < 4 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRst_send", 32'(sendA), 32'd0);
        checkOutput("midRst_busy", 32'(busyA), 32'd0);
        checkOutput("midRst_done", 32'(doneA), 32'd0);
        checkOutput("midRst_data", 32'(dataA), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRst_bytesBefore", 32'(capA.size() - base), 32'd4);
        base2 = capA.size();
        d0    = doneCntA;
        applyStimulus(1'b1, PAYLOAD1);
        checkOutput("midRst_busyWaiting", 32'(busyA), 32'd1);
        cyc = 0;
        while (!readyA && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midRst_noSendInFlight", 32'(capA.size() - base2), 32'd0);
        waitDoneA("midRst_doneTimeout");
        repeat (3) @(negedge clk);
        checkOutput("midRst_doneCount", 32'(doneCntA - d0), 32'd1);
        checkFrameA(base2, frame1Exp, "afterRst");

        // Single-byte payload instance
        base = capB.size();
        d0   = doneCntB;
        @(negedge clk);
        foundB   = 1'b1;
        payloadB = 8'h5A;
        startB   = 1'b1;
        @(negedge clk);
        startB   = 1'b0;
        cyc = 0;
        while (!doneB && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (!doneB) checkOutput("short_doneTimeout", 32'(doneB), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("short_doneCount", 32'(doneCntB - d0), 32'd1);
        checkOutput("short_busyAfter", 32'(busyB), 32'd0);
        checkOutput("short_byteCount", 32'(capB.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < capB.size())
                checkOutput($sformatf("short_byte%0d", i), 32'(capB[base+i]), 32'(frameBExp[i]));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
